// File: rtl/lieat_wbu_pkg.sv
// lieat_wbu_pkg: shared types and constants for the writeback arbiter.
// remove_op codes must stay aligned with the OITF slot numbering.
package lieat_wbu_pkg;

  localparam int RGIDX_SIZE = 5;

  localparam logic [1:0] REMOVE_OP_LSU  = 2'b00;
  localparam logic [1:0] REMOVE_OP_MDU  = 2'b01;
  localparam logic [1:0] REMOVE_OP_NONE = 2'b11;

  // Relative age of the two long buffers; only meaningful while both hold a result
  typedef enum logic [1:0] {
    AGE_TIE = 2'd0,
    AGE_LSU = 2'd1,
    AGE_MDU = 2'd2
  } age_e;

  // Owner of the register-file write port in the current cycle
  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_ALU     = 3'd1,
    SEL_LSU_BUF = 3'd2,
    SEL_MDU_BUF = 3'd3,
    SEL_LSU_BYP = 3'd4,
    SEL_MDU_BYP = 3'd5
  } wb_sel_e;

  // A buffer that survives the cycle is older than one that is (re)loaded;
  // if neither survives, any pair loaded together is a tie.
  function automatic age_e next_age(input logic lsu_stays, input logic mdu_stays,
                                    input age_e cur);
    age_e nxt;
    nxt = cur;
    if (lsu_stays && !mdu_stays)      nxt = AGE_LSU;
    else if (mdu_stays && !lsu_stays) nxt = AGE_MDU;
    else if (!lsu_stays && !mdu_stays) nxt = AGE_TIE;
    return nxt;
  endfunction

endpackage

// File: rtl/lieat_wbu_slot.sv
// lieat_wbu_slot: one-entry valid/ready holding buffer for a long-latency
// result source. Ready while empty or while the held entry retires, so a
// source can stream one result per cycle.
module lieat_wbu_slot
  import lieat_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [RGIDX_SIZE-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  retire,
  input  logic                  bypass,
  output logic                  valid,
  output logic                  wen,
  output logic [RGIDX_SIZE-1:0] rd,
  output logic [XLEN-1:0]       data
);

  logic load;

  assign in_ready = rst | ~valid | retire;
  assign load     = in_valid & in_ready & ~bypass;

  // Capture an accepted result (unless it was written straight through), drop it on retire
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      wen   <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      wen   <= in_wen;
      rd    <= in_rd;
      data  <= in_data;
    end else if (retire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lieat_wbu_arb.sv
// lieat_wbu_arb: writeback arbiter merging the ALU stream with buffered LSU
// and MULDIV results onto the single register-file write port, and pulsing
// the OITF remove interface when a long instruction retires.
// Optional feature: define LIEAT_WBU_BYPASS_EN to let a long result be
// written in its arrival cycle when the port and both buffers are free.
module lieat_wbu_arb
  import lieat_wbu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_wb_valid,
  input  logic                  alu_wb_wen,
  input  logic [RGIDX_SIZE-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]       alu_wb_data,
  output logic                  alu_wb_stall,
  input  logic                  lsu_wb_valid,
  output logic                  lsu_wb_ready,
  input  logic                  lsu_wb_wen,
  input  logic [RGIDX_SIZE-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]       lsu_wb_data,
  input  logic                  mdu_wb_valid,
  output logic                  mdu_wb_ready,
  input  logic                  mdu_wb_wen,
  input  logic [RGIDX_SIZE-1:0] mdu_wb_rd,
  input  logic [XLEN-1:0]       mdu_wb_data,
  output logic                  rf_wen,
  output logic [RGIDX_SIZE-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  remove_ena,
  output logic [1:0]            remove_op
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic                  lsu_v, lsu_w, mdu_v, mdu_w;
  logic [RGIDX_SIZE-1:0] lsu_rd, mdu_rd;
  logic [XLEN-1:0]       lsu_d, mdu_d;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  rr_mdu;
  age_e                  age;
  wb_sel_e               sel;
  logic                  starved, lsu_ret, mdu_ret, lsu_byp, mdu_byp, long_ret;

  lieat_wbu_slot #(.XLEN(XLEN)) u_lsu_slot (
    .clk(clk), .rst(rst),
    .in_valid(lsu_wb_valid), .in_ready(lsu_wb_ready), .in_wen(lsu_wb_wen),
    .in_rd(lsu_wb_rd), .in_data(lsu_wb_data),
    .retire(lsu_ret), .bypass(lsu_byp),
    .valid(lsu_v), .wen(lsu_w), .rd(lsu_rd), .data(lsu_d)
  );

  lieat_wbu_slot #(.XLEN(XLEN)) u_mdu_slot (
    .clk(clk), .rst(rst),
    .in_valid(mdu_wb_valid), .in_ready(mdu_wb_ready), .in_wen(mdu_wb_wen),
    .in_rd(mdu_wb_rd), .in_data(mdu_wb_data),
    .retire(mdu_ret), .bypass(mdu_byp),
    .valid(mdu_v), .wen(mdu_w), .rd(mdu_rd), .data(mdu_d)
  );

  assign starved      = (starve_cnt == CNT_W'(STARVE_MAX)) & (lsu_v | mdu_v);
  assign alu_wb_stall = starved & ~rst;
  assign lsu_ret      = (sel == SEL_LSU_BUF);
  assign mdu_ret      = (sel == SEL_MDU_BUF);
  assign lsu_byp      = (sel == SEL_LSU_BYP);
  assign mdu_byp      = (sel == SEL_MDU_BYP);
  assign long_ret     = lsu_ret | mdu_ret | lsu_byp | mdu_byp;

  // Grant order: starved oldest buffer, then ALU, then buffers round-robin, then bypass
  always_comb begin
    sel = SEL_NONE;
    if (rst) begin
      sel = SEL_NONE;
    end else if (starved) begin
      if (lsu_v & mdu_v) begin
        if (age == AGE_LSU)      sel = SEL_LSU_BUF;
        else if (age == AGE_MDU) sel = SEL_MDU_BUF;
        else                     sel = rr_mdu ? SEL_MDU_BUF : SEL_LSU_BUF;
      end else begin
        sel = lsu_v ? SEL_LSU_BUF : SEL_MDU_BUF;
      end
    end else if (alu_wb_valid) begin
      sel = SEL_ALU;
    end else if (lsu_v & mdu_v) begin
      sel = rr_mdu ? SEL_MDU_BUF : SEL_LSU_BUF;
    end else if (lsu_v) begin
      sel = SEL_LSU_BUF;
    end else if (mdu_v) begin
      sel = SEL_MDU_BUF;
`ifdef LIEAT_WBU_BYPASS_EN
    end else if (lsu_wb_valid & mdu_wb_valid) begin
      sel = rr_mdu ? SEL_MDU_BYP : SEL_LSU_BYP;
    end else if (lsu_wb_valid) begin
      sel = SEL_LSU_BYP;
    end else if (mdu_wb_valid) begin
      sel = SEL_MDU_BYP;
`endif
    end
  end

  // Drive the write port and the OITF retire pulse from the selected owner
  always_comb begin
    rf_wen     = 1'b0;
    rf_rd      = alu_wb_rd;
    rf_wdata   = alu_wb_data;
    remove_ena = 1'b0;
    remove_op  = REMOVE_OP_NONE;
    case (sel)
      SEL_ALU: begin
        rf_wen = alu_wb_valid & alu_wb_wen;
      end
      SEL_LSU_BUF: begin
        rf_wen = lsu_w; rf_rd = lsu_rd; rf_wdata = lsu_d;
        remove_ena = 1'b1; remove_op = REMOVE_OP_LSU;
      end
      SEL_MDU_BUF: begin
        rf_wen = mdu_w; rf_rd = mdu_rd; rf_wdata = mdu_d;
        remove_ena = 1'b1; remove_op = REMOVE_OP_MDU;
      end
      SEL_LSU_BYP: begin
        rf_wen = lsu_wb_wen; rf_rd = lsu_wb_rd; rf_wdata = lsu_wb_data;
        remove_ena = 1'b1; remove_op = REMOVE_OP_LSU;
      end
      SEL_MDU_BYP: begin
        rf_wen = mdu_wb_wen; rf_rd = mdu_wb_rd; rf_wdata = mdu_wb_data;
        remove_ena = 1'b1; remove_op = REMOVE_OP_MDU;
      end
      default: begin
      end
    endcase
  end

  // Count cycles a buffered result loses to the ALU; any long retire clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (long_ret) begin
      starve_cnt <= '0;
    end else if ((lsu_v | mdu_v) && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Round-robin pointer toggles on every long retire, LSU first out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_mdu <= 1'b0;
    end else if (long_ret) begin
      rr_mdu <= ~rr_mdu;
    end
  end

  // Track which buffered result arrived first so starvation serves the oldest
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= AGE_TIE;
    end else begin
      age <= next_age(lsu_v & ~lsu_ret, mdu_v & ~mdu_ret, age);
    end
  end

endmodule

// File: tb/tb_lieat_wbu_arb.sv
// tb_lieat_wbu_arb: self-checking bench for lieat_wbu_arb. A cycle-level
// reference model built on arrival timestamps predicts every output.
// Honours LIEAT_WBU_BYPASS_EN when the build defines it.
module tb_lieat_wbu_arb;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wb_valid = 1'b0, alu_wb_wen = 1'b0;
  logic [4:0]  alu_wb_rd = '0;
  logic [31:0] alu_wb_data = '0;
  logic        alu_wb_stall;
  logic        lsu_wb_valid = 1'b0, lsu_wb_ready, lsu_wb_wen = 1'b0;
  logic [4:0]  lsu_wb_rd = '0;
  logic [31:0] lsu_wb_data = '0;
  logic        mdu_wb_valid = 1'b0, mdu_wb_ready, mdu_wb_wen = 1'b0;
  logic [4:0]  mdu_wb_rd = '0;
  logic [31:0] mdu_wb_data = '0;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        remove_ena;
  logic [1:0]  remove_op;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: buffer contents with arrival cycle, starvation count, pointer
  logic        b_v[2];
  logic        b_w[2];
  logic [4:0]  b_rd[2];
  logic [31:0] b_d[2];
  int          b_t[2];
  int          lost = 0;
  int          rr = 0;
  int          cyc = 0;
  logic        m_rdy[2];
  logic        last_stall = 1'b0;

  lieat_wbu_arb #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_wen(alu_wb_wen), .alu_wb_rd(alu_wb_rd),
    .alu_wb_data(alu_wb_data), .alu_wb_stall(alu_wb_stall),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_wen(lsu_wb_wen),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .mdu_wb_valid(mdu_wb_valid), .mdu_wb_ready(mdu_wb_ready), .mdu_wb_wen(mdu_wb_wen),
    .mdu_wb_rd(mdu_wb_rd), .mdu_wb_data(mdu_wb_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .remove_ena(remove_ena), .remove_op(remove_op)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic r,
    input logic av, input logic aw, input logic [4:0] ard, input logic [31:0] ad,
    input logic lv, input logic lw, input logic [4:0] lrd, input logic [31:0] ld,
    input logic mv, input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    logic        in_v[2];
    logic        in_w[2];
    logic [4:0]  in_rd[2];
    logic [31:0] in_d[2];
    int          win, byp;
    logic        e_alu, e_stall, any_b, e_wen, e_rem;
    logic [4:0]  e_rd;
    logic [31:0] e_d;
    logic [1:0]  e_op;

    @(negedge clk);
    rst = r;
    alu_wb_valid = av; alu_wb_wen = aw; alu_wb_rd = ard; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_wen = lw; lsu_wb_rd = lrd; lsu_wb_data = ld;
    mdu_wb_valid = mv; mdu_wb_wen = mw; mdu_wb_rd = mrd; mdu_wb_data = md;
    in_v[0] = lv; in_w[0] = lw; in_rd[0] = lrd; in_d[0] = ld;
    in_v[1] = mv; in_w[1] = mw; in_rd[1] = mrd; in_d[1] = md;
    #1;

    win = -1; byp = -1; e_alu = 1'b0; e_stall = 1'b0;
    any_b = b_v[0] | b_v[1];
    if (!r) begin
      e_stall = (lost >= STARVE_MAX) && any_b;
      if (e_stall) begin
        if (b_v[0] && b_v[1])
          win = (b_t[0] < b_t[1]) ? 0 : ((b_t[1] < b_t[0]) ? 1 : rr);
        else
          win = b_v[0] ? 0 : 1;
      end else if (av) begin
        e_alu = 1'b1;
      end else if (any_b) begin
        win = (b_v[0] && b_v[1]) ? rr : (b_v[0] ? 0 : 1);
      end
`ifdef LIEAT_WBU_BYPASS_EN
      else if (in_v[0] || in_v[1]) begin
        byp = (in_v[0] && in_v[1]) ? rr : (in_v[0] ? 0 : 1);
      end
`endif
    end

    e_wen = 1'b0; e_rem = 1'b0; e_op = 2'b11; e_rd = '0; e_d = '0;
    if (e_alu) begin
      e_wen = aw; e_rd = ard; e_d = ad;
    end else if (win >= 0) begin
      e_wen = b_w[win]; e_rd = b_rd[win]; e_d = b_d[win]; e_rem = 1'b1; e_op = 2'(win);
    end else if (byp >= 0) begin
      e_wen = in_w[byp]; e_rd = in_rd[byp]; e_d = in_d[byp]; e_rem = 1'b1; e_op = 2'(byp);
    end
    for (int i = 0; i < 2; i++) m_rdy[i] = r | !b_v[i] | (win == i);
    last_stall = e_stall;

    checkOutput("alu_wb_stall", 32'(alu_wb_stall), 32'(e_stall));
    checkOutput("lsu_wb_ready", 32'(lsu_wb_ready), 32'(m_rdy[0]));
    checkOutput("mdu_wb_ready", 32'(mdu_wb_ready), 32'(m_rdy[1]));
    checkOutput("rf_wen", 32'(rf_wen), 32'(e_wen));
    if (e_wen) begin
      checkOutput("rf_rd", 32'(rf_rd), 32'(e_rd));
      checkOutput("rf_wdata", rf_wdata, e_d);
    end
    checkOutput("remove_ena", 32'(remove_ena), 32'(e_rem));
    checkOutput("remove_op", 32'(remove_op), 32'(e_op));

    if (r) begin
      b_v[0] = 1'b0; b_v[1] = 1'b0; lost = 0; rr = 0;
    end else begin
      if (win >= 0) b_v[win] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (in_v[i] && m_rdy[i] && byp != i) begin
          b_v[i] = 1'b1; b_w[i] = in_w[i]; b_rd[i] = in_rd[i]; b_d[i] = in_d[i]; b_t[i] = cyc;
        end
      end
      if (win >= 0 || byp >= 0) begin
        lost = 0; rr = 1 - rr;
      end else if (any_b) begin
        lost++;
      end
    end
    cyc++;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  logic        a_v, a_w, r_q;
  logic [4:0]  a_rd;
  logic [31:0] a_d;
  logic        p_v[2];
  logic        p_w[2];
  logic [4:0]  p_rd[2];
  logic [31:0] p_d[2];

  initial begin
    b_v[0] = 1'b0; b_v[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_w[i] = 1'b0; b_rd[i] = '0; b_d[i] = '0; b_t[i] = 0; m_rdy[i] = 1'b1;
    end

    // reset then check the idle state
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
                             1'b0, 1'b0, 5'd0, 32'd0);
    idleCycle();
    checkOutput("reset_lsu_ready", 32'(lsu_wb_ready), 32'd1);
    checkOutput("reset_mdu_ready", 32'(mdu_wb_ready), 32'd1);
    checkOutput("reset_remove_op", 32'(remove_op), 32'd3);

    // ALU only
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("alu_only_wen", 32'(rf_wen), 32'd1);
    checkOutput("alu_only_rd", 32'(rf_rd), 32'd5);
    checkOutput("alu_only_data", rf_wdata, 32'h1234);
    checkOutput("alu_only_remove_ena", 32'(remove_ena), 32'd0);
    checkOutput("alu_only_remove_op", 32'(remove_op), 32'd3);

    // LSU load, written next cycle or same cycle with bypass
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'hAA,
                  1'b0, 1'b0, 5'd0, 32'd0);
`ifndef LIEAT_WBU_BYPASS_EN
    checkOutput("load_not_early", 32'(remove_ena), 32'd0);
    idleCycle();
`endif
    checkOutput("load_wen", 32'(rf_wen), 32'd1);
    checkOutput("load_rd", 32'(rf_rd), 32'd7);
    checkOutput("load_data", rf_wdata, 32'hAA);
    checkOutput("load_remove_ena", 32'(remove_ena), 32'd1);
    checkOutput("load_remove_op", 32'(remove_op), 32'd0);

    // store retire: no write but the tracker entry clears
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd9, 32'h55,
                  1'b0, 1'b0, 5'd0, 32'd0);
`ifndef LIEAT_WBU_BYPASS_EN
    idleCycle();
`endif
    checkOutput("store_wen", 32'(rf_wen), 32'd0);
    checkOutput("store_remove_ena", 32'(remove_ena), 32'd1);
    checkOutput("store_remove_op", 32'(remove_op), 32'd0);

    // contention: fill both buffers under an ALU write, then drain LSU then MDU
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 1'b1, 5'd2, 32'h22,
                  1'b1, 1'b1, 5'd3, 32'h33);
    idleCycle();
    checkOutput("contend_first_op", 32'(remove_op), 32'd0);
    checkOutput("contend_first_rd", 32'(rf_rd), 32'd2);
    idleCycle();
    checkOutput("contend_second_op", 32'(remove_op), 32'd1);
    checkOutput("contend_second_rd", 32'(rf_rd), 32'd3);

    // starvation: MDU waits behind a continuous ALU stream
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b1, 1'b1, 5'd12, 32'hC0);
    for (int i = 0; i < STARVE_MAX; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 5'd0, 32'd0,
                    1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("starve_no_stall_yet", 32'(alu_wb_stall), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("starve_stall", 32'(alu_wb_stall), 32'd1);
    checkOutput("starve_remove_op", 32'(remove_op), 32'd1);
    checkOutput("starve_rd", 32'(rf_rd), 32'd12);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("starve_alu_after_stall", 32'(alu_wb_stall), 32'd0);
    checkOutput("starve_alu_rd", 32'(rf_rd), 32'd10);

    // reset with both buffers full discards them
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 1'b1, 5'd20, 32'hDEAD,
                  1'b1, 1'b1, 5'd21, 32'hBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("rst_no_write", 32'(rf_wen), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("post_rst_lsu_ready", 32'(lsu_wb_ready), 32'd1);
      checkOutput("post_rst_mdu_ready", 32'(mdu_wb_ready), 32'd1);
      checkOutput("post_rst_remove_ena", 32'(remove_ena), 32'd0);
    end

    // randomized traffic with held valid/ready sources and re-presented stalled ALU
    a_v = 1'b0; a_w = 1'b0; a_rd = '0; a_d = '0;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0; p_w[i] = 1'b0; p_rd[i] = '0; p_d[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      r_q = ($urandom_range(0, 199) == 0);
      if (!(last_stall && a_v)) begin
        a_v = ($urandom_range(0, 99) < 75);
        a_w = ($urandom_range(0, 3) != 0);
        a_rd = 5'($urandom); a_d = $urandom;
      end
      for (int i = 0; i < 2; i++) begin
        if (!p_v[i] && $urandom_range(0, 1) == 1) begin
          p_v[i] = 1'b1; p_w[i] = ($urandom_range(0, 3) != 0);
          p_rd[i] = 5'($urandom); p_d[i] = $urandom;
        end
      end
      applyStimulus(r_q, a_v, a_w, a_rd, a_d, p_v[0], p_w[0], p_rd[0], p_d[0],
                    p_v[1], p_w[1], p_rd[1], p_d[1]);
      for (int i = 0; i < 2; i++) if (p_v[i] && m_rdy[i]) p_v[i] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lieat_wbu_arb.md
# lieat_wbu_arb

Writeback arbiter between the execute stage and the register file. It merges the single-cycle ALU result stream with the long-latency LSU and MULDIV result streams onto the one register-file write port. Each long source gets a one-entry holding buffer. When a long instruction retires, the block issues the `remove_ena`/`remove_op` pulse that clears that instruction's entry in the outstanding-instruction (OITF) dependency tracker.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `STARVE_MAX`, 4, number of cycles a buffered long result may lose to the ALU before the ALU is stalled.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `alu_wb_valid`  in  1  ALU result present this cycle.
- `alu_wb_wen`  in  1  ALU result writes the register file.
- `alu_wb_rd`  in  `RGIDX_SIZE`  ALU destination register index.
- `alu_wb_data`  in  XLEN  ALU result data.
- `alu_wb_stall`  out  1  ALU must hold its result; upstream re-presents it next cycle.
- `lsu_wb_valid`  in  1  LSU result offered.
- `lsu_wb_ready`  out  1  LSU handshake ready.
- `lsu_wb_wen`  in  1  LSU result writes the register file.
- `lsu_wb_rd`  in  `RGIDX_SIZE`  LSU destination register index.
- `lsu_wb_data`  in  XLEN  LSU result data.
- `mdu_wb_valid`  in  1  MULDIV result offered.
- `mdu_wb_ready`  out  1  MULDIV handshake ready.
- `mdu_wb_wen`  in  1  MULDIV result writes the register file.
- `mdu_wb_rd`  in  `RGIDX_SIZE`  MULDIV destination register index.
- `mdu_wb_data`  in  XLEN  MULDIV result data.
- `rf_wen`  out  1  register-file write enable.
- `rf_rd`  out  `RGIDX_SIZE`  register-file write index.
- `rf_wdata`  out  XLEN  register-file write data.
- `remove_ena`  out  1  retire pulse to the dependency tracker.
- `remove_op`  out  2  retired slot: 2'b00 LSU, 2'b01 MULDIV, 2'b11 none.

## Operation
- A long source transfers a result on `*_wb_valid & *_wb_ready`. The result goes into that source's buffer holding valid, wen, rd and data.
- `*_wb_ready` is high when the source's buffer is empty, or when the buffer is retiring in the current cycle.
- Write-port grant, checked in this order each cycle:
  1. Starved long buffer.
  2. ALU.
  3. Long buffers, round-robin.
- Round-robin pointer:
  - Reset value is LSU-first.
  - It flips to the other source after each long retire.
  - When only one buffer is valid, that buffer wins.
- Starvation counter:
  - It increments each cycle a long buffer is valid but not granted.
  - It clears to 0 on any long retire.
  - At `STARVE_MAX` the oldest waiting buffer (round-robin pointer breaks ties) takes priority over the ALU, and `alu_wb_stall`=1 that cycle.
  - `alu_wb_stall` depends only on registered state, never on `alu_wb_valid`.
- Long retire:
  - The buffer empties.
  - `rf_wen` = the buffer's wen.
  - `remove_ena`=1 and `remove_op` = the source code.
  - `remove_ena` pulses even when wen=0 (stores), because the OITF entry must still clear.
- ALU grant: `rf_wen` = `alu_wb_valid & alu_wb_wen`, `remove_ena`=0, `remove_op`=2'b11.
- Idle cycle: `rf_wen`=0, `remove_ena`=0, `remove_op`=2'b11. `rf_rd` and `rf_wdata` are don't-care whenever `rf_wen`=0.
- Reset:
  - Both buffers become invalid.
  - The starvation counter and the round-robin pointer return to their reset values.
  - All outputs go low, with `remove_op`=2'b11 and both readys = 1.
- Reset mid-operation discards buffered results. The OITF is reset in the same cycle, so no retire pulse is owed.

## Timing
- All outputs except readys are combinational from registered buffer state plus the ALU inputs and, when bypass is enabled, the long-source inputs.
- Without bypass: a long result accepted at cycle N is written at cycle N+1 at the earliest.
- With bypass: see Configuration.
- At most one rf write and at most one `remove_ena` per cycle.
- A buffer retiring in cycle N can accept a new result in the same cycle N. This gives a throughput of 1 result per cycle per source.
- `remove_ena` is coincident with the rf write of the same instruction, so the tracker clears in the same cycle the value lands.

## Configuration
- `LIEAT_WBU_BYPASS_EN` defined:
  - When the ALU is not granted and both buffers are empty, a long result offered in cycle N is written and retired in cycle N without being buffered.
  - If both sources are offered in that situation, the round-robin pointer picks one; the other is buffered.
- Not defined: every long result passes through its buffer, giving a minimum latency of 1 cycle.

## Structure
- Shared package/defines:
  - `RGIDX_SIZE`.
  - `remove_op` encodings: LSU=2'b00, MDU=2'b01, NONE=2'b11. These must match the tracker's slot numbering.
- One sub-module, instantiated twice (LSU and MULDIV): `lieat_wbu_slot`, a one-entry valid/ready holding buffer.
- Registers use the existing `lieat_general_dfflr` style with the synchronous active-high reset.

## Test plan
- ALU only: `alu_wb_valid`=1, wen=1, rd=5, data=0x1234 -> same-cycle `rf_wen`=1, `rf_rd`=5, `rf_wdata`=0x1234, `remove_ena`=0, `remove_op`=2'b11.
- LSU load:
  - Accept rd=7, data=0xAA at cycle 0 with the ALU idle.
  - Without bypass: cycle 1 gives `rf_wen`=1, `rf_rd`=7, `remove_ena`=1, `remove_op`=2'b00.
  - With bypass: the same response at cycle 0.
- Store retire: MULDIV-free LSU result with wen=0 -> `rf_wen`=0, `remove_ena`=1, `remove_op`=2'b00.
- Contention: both buffers valid and the ALU idle for 2 cycles -> LSU retires first, MULDIV second (`remove_op` 00 then 01).
- Starvation:
  - `STARVE_MAX`=4; hold `alu_wb_valid`=1 with the MULDIV buffer valid.
  - After 4 lost cycles, `alu_wb_stall`=1 and MULDIV retires with `remove_op`=2'b01.
  - The next cycle writes the ALU result.
- Reset: assert `rst` with both buffers full -> next cycle both readys = 1, `remove_ena`=0, and no write of the stale data ever occurs.
